// File: rtl/pio_ram_emu_bfm.sv
// 2-pin serial RAM emulator: decodes requests on rx_pins, answers reads on tx_pins.
// Define PIO_RAM_EMU_INIT_EN to preload mem[i] = {i[7:0], i[7:0]} on every reset.
module pio_ram_emu_bfm #(
  parameter int IO_BITS        = 2,
  parameter int ADDR_BITS      = 8,
  parameter int READ_LATENCY   = 22,
  parameter bit ERROR_RESPONSE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IO_BITS-1:0] rx_pins,
  output logic [IO_BITS-1:0] tx_pins
);

  if (IO_BITS != 2 || READ_LATENCY < 12 || READ_LATENCY > 255) begin : g_bad_param
    $fatal(1, "pio_ram_emu_bfm: IO_BITS must be 2 and READ_LATENCY 12..255");
  end

  localparam int DEPTH = 2 ** ADDR_BITS;
  // The counter is loaded on the cmd edge, one edge after the start symbol.
  localparam logic [7:0]           LAT_LOAD = 8'(READ_LATENCY - 2);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [1:0] CMD_READ4 = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_BAD   = 2'b11;

  typedef enum logic [1:0] {RX_IDLE, RX_CMD, RX_ADDR, RX_DATA} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_STAT, TX_DATA} tx_state_t;

  rx_state_t            rx_state_reg, rx_state_next;
  logic [2:0]           rx_cnt_reg, rx_cnt_next;
  logic [1:0]           cmd_reg, cmd_next;
  logic                 busy_at_start_reg, busy_at_start_next;
  logic [15:0]          addr_sr_reg, addr_sr_next;
  logic [13:0]          data_sr_reg, data_sr_next;
  logic                 pend_reg, pend_next;
  logic                 pend_err_reg, pend_err_next;
  logic                 pend_four_reg, pend_four_next;
  logic [ADDR_BITS-1:0] pend_addr_reg, pend_addr_next;
  logic [7:0]           lat_cnt_reg, lat_cnt_next;
  logic                 err_flag_reg, err_flag_next;
  tx_state_t            tx_state_reg, tx_state_next;
  logic [2:0]           sym_cnt_reg, sym_cnt_next;
  logic [1:0]           words_left_reg, words_left_next;
  logic [ADDR_BITS-1:0] tx_addr_reg, tx_addr_next;
  logic                 tx_err_reg, tx_err_next;
  logic [1:0]           tx_pins_reg, tx_pins_next;

  logic                 busy;
  logic [15:0]          addr_sh;
  logic [15:0]          data_sh;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [15:0]          wr_data;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [15:0]          rd_data_reg;
  logic [15:0]          mem [DEPTH];

  assign tx_pins = tx_pins_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg      <= RX_IDLE;
      rx_cnt_reg        <= '0;
      cmd_reg           <= '0;
      busy_at_start_reg <= 1'b0;
      addr_sr_reg       <= '0;
      data_sr_reg       <= '0;
      pend_reg          <= 1'b0;
      pend_err_reg      <= 1'b0;
      pend_four_reg     <= 1'b0;
      pend_addr_reg     <= '0;
      lat_cnt_reg       <= '0;
      err_flag_reg      <= 1'b0;
      tx_state_reg      <= TX_IDLE;
      sym_cnt_reg       <= '0;
      words_left_reg    <= '0;
      tx_addr_reg       <= '0;
      tx_err_reg        <= 1'b0;
      tx_pins_reg       <= '0;
    end else begin
      rx_state_reg      <= rx_state_next;
      rx_cnt_reg        <= rx_cnt_next;
      cmd_reg           <= cmd_next;
      busy_at_start_reg <= busy_at_start_next;
      addr_sr_reg       <= addr_sr_next;
      data_sr_reg       <= data_sr_next;
      pend_reg          <= pend_next;
      pend_err_reg      <= pend_err_next;
      pend_four_reg     <= pend_four_next;
      pend_addr_reg     <= pend_addr_next;
      lat_cnt_reg       <= lat_cnt_next;
      err_flag_reg      <= err_flag_next;
      tx_state_reg      <= tx_state_next;
      sym_cnt_reg       <= sym_cnt_next;
      words_left_reg    <= words_left_next;
      tx_addr_reg       <= tx_addr_next;
      tx_err_reg        <= tx_err_next;
      tx_pins_reg       <= tx_pins_next;
    end
  end

  always_comb begin
    rx_state_next      = rx_state_reg;
    rx_cnt_next        = rx_cnt_reg;
    cmd_next           = cmd_reg;
    busy_at_start_next = busy_at_start_reg;
    addr_sr_next       = addr_sr_reg;
    data_sr_next       = data_sr_reg;
    pend_next          = pend_reg;
    pend_err_next      = pend_err_reg;
    pend_four_next     = pend_four_reg;
    pend_addr_next     = pend_addr_reg;
    lat_cnt_next       = lat_cnt_reg;
    err_flag_next      = err_flag_reg;
    tx_state_next      = tx_state_reg;
    sym_cnt_next       = sym_cnt_reg;
    words_left_next    = words_left_reg;
    tx_addr_next       = tx_addr_reg;
    tx_err_next        = tx_err_reg;
    tx_pins_next       = 2'b00;
    wr_en              = 1'b0;
    wr_addr            = addr_sr_reg[ADDR_BITS-1:0];
    wr_data            = '0;
    rd_en              = 1'b0;
    rd_addr            = tx_addr_reg;

    busy    = pend_reg | err_flag_reg | (tx_state_reg != TX_IDLE) | (words_left_reg != 2'd0);
    addr_sh = {rx_pins, addr_sr_reg[15:2]};
    data_sh = {rx_pins, data_sr_reg};

    if (pend_reg && lat_cnt_reg != 8'd0) lat_cnt_next = lat_cnt_reg - 8'd1;

    // Reply sequencer: READ4 continuation first, then the scheduled slot, then a deferred error.
    case (tx_state_reg)
      TX_IDLE: begin
        if (words_left_reg != 2'd0) begin
          tx_state_next   = TX_STAT;
          tx_pins_next    = 2'b01;
          words_left_next = words_left_reg - 2'd1;
          tx_addr_next    = tx_addr_reg + ADDR_ONE;
          tx_err_next     = 1'b0;
          rd_en           = 1'b1;
          rd_addr         = tx_addr_reg + ADDR_ONE;
        end else if (pend_reg && lat_cnt_reg == 8'd0) begin
          tx_state_next   = TX_STAT;
          tx_pins_next    = pend_err_reg ? 2'b11 : 2'b01;
          pend_next       = 1'b0;
          words_left_next = pend_four_reg ? 2'd3 : 2'd0;
          tx_addr_next    = pend_addr_reg;
          tx_err_next     = pend_err_reg;
          rd_en           = ~pend_err_reg;
          rd_addr         = pend_addr_reg;
        end else if (err_flag_reg && !pend_reg) begin
          tx_state_next = TX_STAT;
          tx_pins_next  = 2'b11;
          err_flag_next = 1'b0;
          tx_err_next   = 1'b1;
        end
      end
      TX_STAT: begin
        tx_state_next = TX_DATA;
        tx_pins_next  = tx_err_reg ? 2'b00 : rd_data_reg[1:0];
        sym_cnt_next  = 3'd1;
      end
      TX_DATA: begin
        tx_pins_next = tx_err_reg ? 2'b00 : rd_data_reg[{sym_cnt_reg, 1'b0} +: 2];
        sym_cnt_next = sym_cnt_reg + 3'd1;
        if (sym_cnt_reg == 3'd7) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase

    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_pins[0]) begin
          rx_state_next      = RX_CMD;
          busy_at_start_next = busy;
        end
      end
      RX_CMD: begin
        cmd_next      = rx_pins;
        rx_cnt_next   = 3'd0;
        rx_state_next = RX_ADDR;
        if (rx_pins != CMD_WRITE && (ERROR_RESPONSE || rx_pins != CMD_BAD)) begin
          if (!busy_at_start_reg) begin
            pend_next      = 1'b1;
            pend_err_next  = (rx_pins == CMD_BAD);
            pend_four_next = (rx_pins == CMD_READ4);
            lat_cnt_next   = LAT_LOAD;
          end else if (ERROR_RESPONSE) begin
            err_flag_next = 1'b1;
          end
        end
      end
      RX_ADDR: begin
        addr_sr_next = addr_sh;
        rx_cnt_next  = rx_cnt_reg + 3'd1;
        if (rx_cnt_reg == 3'd7) begin
          rx_cnt_next   = 3'd0;
          rx_state_next = (cmd_reg == CMD_WRITE) ? RX_DATA : RX_IDLE;
          if (!busy_at_start_reg) pend_addr_next = addr_sh[ADDR_BITS-1:0];
        end
      end
      RX_DATA: begin
        data_sr_next = data_sh[15:2];
        rx_cnt_next  = rx_cnt_reg + 3'd1;
        if (rx_cnt_reg == 3'd7) begin
          rx_state_next = RX_IDLE;
          wr_en         = 1'b1;
          wr_data       = data_sh;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

`ifdef PIO_RAM_EMU_INIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[ADDR_BITS'(i)] <= {2{8'(i)}};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
`endif

  // Word is fetched on the status edge so any earlier write is already visible.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_reg <= mem[rd_addr];
  end

endmodule

// File: tb/tb_pio_ram_emu_bfm.sv
// Bench for pio_ram_emu_bfm: two instances (error replies on / off) share one request line.
module tb_pio_ram_emu_bfm;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rx;
  logic [1:0] tx_a;
  logic [1:0] tx_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pio_ram_emu_bfm #(.IO_BITS(2), .ADDR_BITS(8), .READ_LATENCY(22), .ERROR_RESPONSE(1'b1)) dut (
    .clk(clk), .reset(rst), .rx_pins(rx), .tx_pins(tx_a));

  pio_ram_emu_bfm #(.IO_BITS(2), .ADDR_BITS(8), .READ_LATENCY(22), .ERROR_RESPONSE(1'b0)) dut_quiet (
    .clk(clk), .reset(rst), .rx_pins(rx), .tx_pins(tx_b));

  typedef struct {
    int         start;
    logic [1:0] status;
    logic [15:0] data;
  } reply_t;

  reply_t      q0[$];
  reply_t      q1[$];
  logic [15:0] model_mem [256];

  // Reply monitor / scoreboard, sampled on the falling edge.
  logic [1:0]  txv [2];
  bit          in_rep [2];
  int          idx [2];
  int          rstart [2];
  logic [1:0]  rstat [2];
  logic [15:0] rdata [2];

  assign txv[0] = tx_a;
  assign txv[1] = tx_b;

  always @(negedge clk) begin
    reply_t exp_r;
    bit     have;
    if (rst) begin
      in_rep[0] = 1'b0;
      in_rep[1] = 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (!in_rep[ch]) begin
          if (txv[ch] != 2'b00) begin
            in_rep[ch] = 1'b1;
            idx[ch]    = 0;
            rstart[ch] = cyc;
            rstat[ch]  = txv[ch];
            rdata[ch]  = 16'h0000;
          end
        end else begin
          rdata[ch][2*idx[ch] +: 2] = txv[ch];
          idx[ch] = idx[ch] + 1;
          if (idx[ch] == 8) begin
            in_rep[ch] = 1'b0;
            $display("reply ch=%0d start=%0d status=%b data=%h", ch, rstart[ch], rstat[ch], rdata[ch]);
            have = (ch == 0) ? (q0.size() != 0) : (q1.size() != 0);
            checks++;
            if (!have) begin
              failures++;
              $display("FAIL unexpected_reply ch=%0d got start=%0d status=%b data=%h required none",
                       ch, rstart[ch], rstat[ch], rdata[ch]);
            end else begin
              exp_r = (ch == 0) ? q0.pop_front() : q1.pop_front();
              if (rstart[ch] !== exp_r.start || rstat[ch] !== exp_r.status || rdata[ch] !== exp_r.data) begin
                failures++;
                $display("FAIL reply ch=%0d got start=%0d status=%b data=%h required start=%0d status=%b data=%h",
                         ch, rstart[ch], rstat[ch], rdata[ch], exp_r.start, exp_r.status, exp_r.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic expect_reply(input bit both, input int start, input logic [1:0] st, input logic [15:0] d);
    reply_t r;
    r.start  = start;
    r.status = st;
    r.data   = d;
    q0.push_back(r);
    if (both) q1.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 2'b00;
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [15:0] addr, input logic [15:0] data, output int t0);
    @(negedge clk);
    rx = 2'b01;
    t0 = cyc + 1;
    @(negedge clk);
    rx = cmd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = addr[2*i +: 2];
    end
    if (cmd == 2'b10) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        rx = data[2*i +: 2];
      end
      model_mem[addr[7:0]] = data;
    end
    @(negedge clk);
    rx = 2'b00;
    $display("request cmd=%b addr=%h data=%h start=%0d", cmd, addr, data, t0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef PIO_RAM_EMU_INIT_EN
    for (int i = 0; i < 256; i++) model_mem[i] = {2{8'(i)}};
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || in_rep[0] || in_rep[1]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d/%0d required 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    idle(12);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== 2'b00 || tx_b !== 2'b00) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got tx_a=%b tx_b=%b required 00", i, tx_a, tx_b);
      end
    end
  endtask

  task automatic test_write_read();
    logic [15:0] wa [3];
    logic [15:0] wd [3];
    logic [15:0] ra [3];
    int t;
    wa = '{16'h0012, 16'h0005, 16'h1234};
    wd = '{16'h1212, 16'hBEEF, 16'hA5C3};
    ra = '{16'h0012, 16'h0005, 16'h0034};
    for (int i = 0; i < 3; i++) send(2'b10, wa[i], wd[i], t);
    for (int i = 0; i < 3; i++) begin
      send(2'b00, ra[i], 16'h0000, t);
      expect_reply(1'b1, t + 22, 2'b01, model_mem[ra[i][7:0]]);
      drain();
    end
  endtask

  task automatic test_read4();
    logic [15:0] a;
    int t;
    a = 16'h00FE;
    send(2'b10, 16'h00FE, 16'hF0E1, t);
    send(2'b10, 16'h00FF, 16'h0F1E, t);
    send(2'b10, 16'h0000, 16'h7A5A, t);
    send(2'b10, 16'h0001, 16'hC33C, t);
    send(2'b01, a, 16'h0000, t);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] wa;
      wa = a[7:0] + 8'(k);
      expect_reply(1'b1, t + 22 + 9 * k, 2'b01, model_mem[wa]);
    end
    drain();
  endtask

  task automatic test_invalid_cmd();
    int t;
    int quiet_hits;
    quiet_hits = 0;
    send(2'b11, 16'h0005, 16'h0000, t);
    expect_reply(1'b0, t + 22, 2'b11, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_b !== 2'b00) quiet_hits++;
    end
    checks++;
    if (quiet_hits != 0) begin
      failures++;
      $display("FAIL invalid_silent got nonzero_cycles=%0d required 0", quiet_hits);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    send(2'b00, 16'h0005, 16'h0000, t1);
    idle(1);
    send(2'b00, 16'h0012, 16'h0000, t2);
    expect_reply(1'b1, t1 + 22, 2'b01, model_mem[8'h05]);
    expect_reply(1'b0, t1 + 31, 2'b11, 16'h0000);
    drain();
  endtask

  task automatic test_reset_midflight();
    int t;
    @(negedge clk);
    rx = 2'b01;
    @(negedge clk);
    rx = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = 2'b10;
    end
    do_reset();
    send(2'b00, 16'h0005, 16'h0000, t);
    idle(3);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== 2'b00 || tx_b !== 2'b00) begin
        failures++;
        $display("FAIL reset_cancel cycle=%0d got tx_a=%b tx_b=%b required 00", i, tx_a, tx_b);
      end
    end
    send(2'b00, 16'h0005, 16'h0000, t);
    expect_reply(1'b1, t + 22, 2'b01, model_mem[8'h05]);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    rx  = 2'b00;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_read4();
    test_invalid_cmd();
    test_back_to_back();
    test_reset_midflight();
    idle(30);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got %0d/%0d required 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
